// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Groups the bus-level signals of the instruction-fetch stage: the
//   instruction-memory read port and the IF/ID pipeline register that feeds
//   decode.
//
//   master (fetch stage side)
//     imem_addr   out  PC_W     instruction-memory address
//     imem_data   in   INSTR_W  instruction at imem_addr (combinational read)
//     ifid_instr  out  INSTR_W  IF/ID instruction
//     ifid_pc     out  PC_W     IF/ID PC of that instruction
//     ifid_valid  out  1        IF/ID holds a real instruction
//   slave (memory / decode side): same signals, opposite directions.
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic               ifid_valid;

  modport master (
    output imem_addr,
    input  imem_data,
    output ifid_instr,
    output ifid_pc,
    output ifid_valid
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   IF stage of the pipelined LEGv8 processor. Owns the PC register, drives
//   the instruction-memory address and loads the IF/ID pipeline register.
//   Accepts a stall from the hazard unit and a taken-branch redirect from
//   EX/MEM, and keeps saturating fetch / flush counters.
//
//   Ports
//     CLK            in   1        clock, all state updates on posedge
//     resetl         in   1        synchronous active-low reset
//     startpc        in   PC_W     PC loaded while resetl is low
//     stall          in   1        hold PC and IF/ID
//     branch_taken   in   1        redirect request
//     branch_target  in   PC_W     redirect address (low two bits dropped)
//     currentpc      out  PC_W     current PC register
//     fetch_count    out  CNT_W    instructions delivered into IF/ID (saturating)
//     flush_count    out  CNT_W    redirects taken (saturating)
//     bus            master modport of fetch_stage_if (imem port + IF/ID)
//
//   Sequencing
//     BOOT : one cycle after reset release; PC held, IF/ID stays a bubble,
//            stall and redirect are ignored.
//     RUN  : per edge, redirect > stall > advance.
//   All outputs are straight register copies; there is no combinational path
//   from stall or branch_taken to any output.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                  PC_W      = 64,
  parameter int                  INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'hD503201F,
  parameter int                  CNT_W     = 32
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic [PC_W-1:0]   startpc,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   currentpc,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [CNT_W-1:0]  flush_count,
  fetch_stage_if.master     bus
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Registered state
  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ifid_instr_q;
  logic [PC_W-1:0]    ifid_pc_q;
  logic               ifid_valid_q;
  logic [CNT_W-1:0]   fetch_cnt_q;
  logic [CNT_W-1:0]   flush_cnt_q;

  // Next-state values
  state_t             state_d;
  logic [PC_W-1:0]    pc_d;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_d;
  logic               ifid_valid_d;
  logic [CNT_W-1:0]   fetch_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_d;

  // Saturating increments: stick at all-ones rather than wrap to zero.
  logic [CNT_W-1:0]   fetch_cnt_inc;
  logic [CNT_W-1:0]   flush_cnt_inc;

  // Redirect target forced to a word boundary.
  logic [PC_W-1:0]    redirect_pc;

  assign fetch_cnt_inc = (fetch_cnt_q == CNT_MAX) ? fetch_cnt_q : fetch_cnt_q + CNT_ONE;
  assign flush_cnt_inc = (flush_cnt_q == CNT_MAX) ? flush_cnt_q : flush_cnt_q + CNT_ONE;
  assign redirect_pc   = {branch_target[PC_W-1:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold value first so no path through the
    // case/if tree leaves one unassigned, which would infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    unique case (state_q)
      BOOT: begin
        // Single settling cycle: imem sees startpc before anything is latched.
        state_d = RUN;
      end

      RUN: begin
        if (branch_taken) begin
          // Redirect wins over a simultaneous stall: the stalled instruction
          // is on the wrong path anyway, so it is squashed into a bubble.
          pc_d         = redirect_pc;
          ifid_instr_d = NOP_INSTR;
          ifid_pc_d    = '0;
          ifid_valid_d = 1'b0;
          flush_cnt_d  = flush_cnt_inc;
        end else if (!stall) begin
          // pc + 4 wraps naturally at the register width.
          pc_d         = pc_q + PC_STEP;
          ifid_instr_d = bus.imem_data;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          fetch_cnt_d  = fetch_cnt_inc;
        end
        // stall without redirect: everything holds (defaults above).
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!resetl) begin
      // Reset overrides stall and redirect, including mid-run.
      state_q      <= BOOT;
      pc_q         <= startpc;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure register copies
  // ---------------------------------------------------------------------------
  assign bus.imem_addr  = pc_q;
  assign currentpc      = pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign fetch_count    = fetch_cnt_q;
  assign flush_count    = flush_cnt_q;

endmodule
